if_stage: RTL and testbench

Instruction-fetch stage of the five-stage ARM-subset pipeline, directly upstream of the decode stage. Holds the program counter, fetches from instruction memory through a request/ready handshake, and drives the IF/ID pipeline register (`PC_out`, `instruction`, `valid`) that the decode stage consumes. Honours `freeze` from the hazard unit and `branch_taken`/`branch_addr` from the execute stage, buffering or discarding in-flight fetches as required.

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 179 +++++++++++++++++
 tb/tb_if_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready channel; if_stage is the master, the memory is the slave.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request/ready fetch, IF/ID register with freeze and branch redirect.
// Optional fetch/stall performance counters are enabled with `define IF_PERF_COUNTERS_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    if_stage_if.master  imem,
    output logic [31:0] PC_out,
    output logic [31:0] instruction,
    output logic        valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_inc;
    logic            bubble;

    assign pc_inc = pc_q + PC_STEP;

    // Request is suppressed during reset so an outstanding fetch is abandoned immediately.
    assign imem.imem_req  = !rst && (state_q != S_HOLD);
    assign imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

    assign PC_out      = pc_out_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

    // Next-state and IF/ID update; a redirect always squashes IF/ID, even under freeze.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        bubble      = 1'b0;

        case (state_q)
            S_REQ: begin
                if (branch_taken) begin
                    bubble = 1'b1;
                    pc_d   = branch_addr;
                    if (!imem.imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_inc;
                    if (freeze) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc_d    = pc_inc;
                        state_d     = S_HOLD;
                    end else begin
                        pc_out_d = pc_inc;
                        instr_d  = imem.imem_rdata;
                        valid_d  = 1'b1;
                    end
                end else if (!freeze) begin
                    bubble = 1'b1;
                end
            end
            S_DROP: begin
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
                if (branch_taken || !freeze) begin
                    bubble = 1'b1;
                end
                if (imem.imem_ready) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    bubble      = 1'b1;
                    pc_d        = branch_addr;
                    buf_instr_d = '0;
                    buf_pc_d    = '0;
                    state_d     = S_REQ;
                end else if (!freeze) begin
                    pc_out_d = buf_pc_q;
                    instr_d  = buf_instr_q;
                    valid_d  = 1'b1;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (bubble) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end
    end

    // State and pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            pc_out_q    <= '0;
            instr_q     <= NOP_WORD;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic [XLEN-1:0] stall_count_q, stall_count_d;
    logic            fetch_load_c;
    logic            stall_c;

    assign fetch_load_c = !branch_taken && !freeze &&
                          (((state_q == S_REQ) && imem.imem_ready) || (state_q == S_HOLD));
    assign stall_c      = freeze || ((state_q == S_REQ) && !imem.imem_ready);

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (fetch_load_c) begin
            fetch_count_d = fetch_count_q + XLEN'(1);
        end
        if (stall_c) begin
            stall_count_d = stall_count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random ready/freeze/branch/reset, checked against
// a program-order instruction stream held in a scoreboard queue.
module tb_if_stage;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam int          STREAM_LEN = 4096;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC_out;
    logic [31:0] instruction;
    logic        valid;
    logic [31:0] mem_key;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int   total    = 0;
    int   bad      = 0;
    int   consumed = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    if_stage_if ifc ();

    if_stage #(
        .RESET_PC(RESET_PC),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem        (ifc),
        .PC_out      (PC_out),
        .instruction (instruction),
        .valid       (valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a keyed function of the address.
    always_comb ifc.imem_rdata = ifc.imem_addr ^ mem_key;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_if(input string nm, input logic [31:0] p, input logic [31:0] i, input logic v);
        chk({nm, "_pc"}, PC_out, p);
        chk({nm, "_instr"}, instruction, i);
        chk({nm, "_valid"}, 32'(valid), 32'(v));
    endtask

    // Program order from a new start address: each delivered word is (addr+4, mem[addr]).
    task automatic restart(input logic [31:0] a);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < STREAM_LEN; i++) begin
            e.pc  = a + 32'(4 * (i + 1));
            e.ins = (a + 32'(4 * i)) ^ mem_key;
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: IF/ID content is consumed at an edge with no freeze, branch or reset.
    logic        prev_rst  = 1'b1;
    logic        prev_br   = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_in_reset", 32'(ifc.imem_req), 32'd0);
            if (prev_rst) begin
                expect_if("reset_vals", 32'd0, NOP_WORD, 1'b0);
            end
        end else begin
            if (!valid) begin
                chk("bubble_nop", instruction, NOP_WORD);
            end
            if (prev_br && !prev_rst) begin
                chk("branch_bubble", 32'(valid), 32'd0);
            end
            if (prev_pend && !prev_rst) begin
                chk("addr_stable", ifc.imem_addr, prev_addr);
                chk("req_held", 32'(ifc.imem_req), 32'd1);
            end
            if (valid && !freeze && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h with no expected entry at t=%0t", PC_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_pc", PC_out, mon_e.pc);
                    chk("sb_instr", instruction, mon_e.ins);
                    consumed++;
                end
            end
        end
        prev_rst  <= rst;
        prev_br   <= branch_taken;
        prev_pend <= ifc.imem_req && !ifc.imem_ready;
        prev_addr <= ifc.imem_addr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_addr    = '0;
        ifc.imem_ready = 1'b0;
        mem_key        = '0;
        restart(RESET_PC);
        repeat (3) cyc();

        // Zero-wait sequential fetch with addr-as-data memory.
        rst = 1'b0; ifc.imem_ready = 1'b1;
        @(negedge clk);
        expect_if("post_reset", 32'd0, NOP_WORD, 1'b0);
        chk("first_req", 32'(ifc.imem_req), 32'd1);
        chk("first_addr", ifc.imem_addr, RESET_PC);
        cyc(); @(negedge clk); expect_if("seq0", 32'd4, 32'd0, 1'b1); chk("seq0_addr", ifc.imem_addr, 32'd4);
        cyc(); ifc.imem_ready = 1'b0;
        @(negedge clk); expect_if("seq1", 32'd8, 32'd4, 1'b1); chk("seq1_addr", ifc.imem_addr, 32'd8);

        // Three wait cycles at address 8.
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 2) ifc.imem_ready = 1'b1;
            @(negedge clk); expect_if("wait_bubble", 32'd8, NOP_WORD, 1'b0);
            chk("wait_addr", ifc.imem_addr, 32'd8);
        end
        cyc(); @(negedge clk); expect_if("after_wait", 32'd12, 32'd8, 1'b1); chk("aw_addr", ifc.imem_addr, 32'd12);

        // Freeze for two edges while the word at 16 is accepted.
        cyc(); freeze = 1'b1;
        @(negedge clk); expect_if("pre_freeze", 32'd16, 32'd12, 1'b1); chk("pf_addr", ifc.imem_addr, 32'd16);
        cyc(); @(negedge clk); expect_if("freeze0", 32'd16, 32'd12, 1'b1); chk("hold_req0", 32'(ifc.imem_req), 32'd0);
        cyc(); freeze = 1'b0;
        @(negedge clk); expect_if("freeze1", 32'd16, 32'd12, 1'b1); chk("hold_req1", 32'(ifc.imem_req), 32'd0);
        cyc(); @(negedge clk); expect_if("release", 32'd20, 32'd16, 1'b1); chk("rel_addr", ifc.imem_addr, 32'd20);

        // Branch to 0x100 while the request at 24 waits.
        cyc(); ifc.imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100; restart(32'h100);
        @(negedge clk); expect_if("pre_branch", 32'd24, 32'd20, 1'b1); chk("pb_addr", ifc.imem_addr, 32'd24);
        cyc(); branch_taken = 1'b0;
        @(negedge clk); expect_if("drop0", 32'd24, NOP_WORD, 1'b0); chk("drop0_addr", ifc.imem_addr, 32'd24);
        cyc(); ifc.imem_ready = 1'b1;
        @(negedge clk); chk("drop1_addr", ifc.imem_addr, 32'd24); chk("drop1_valid", 32'(valid), 32'd0);
        cyc(); @(negedge clk); chk("redirect_addr", ifc.imem_addr, 32'h100); chk("drop_discard", 32'(valid), 32'd0);
        cyc(); freeze = 1'b1;
        @(negedge clk); expect_if("target", 32'h104, 32'h100, 1'b1);

        // Branch with freeze while in HOLD.
        cyc(); branch_taken = 1'b1; branch_addr = 32'h200; restart(32'h200);
        @(negedge clk); chk("hold_b_req", 32'(ifc.imem_req), 32'd0);
        cyc(); branch_taken = 1'b0; freeze = 1'b0;
        @(negedge clk); expect_if("hold_branch", 32'h104, NOP_WORD, 1'b0); chk("hb_addr", ifc.imem_addr, 32'h200);
        chk("hb_req", 32'(ifc.imem_req), 32'd1);

        // PC wrap at the top of the address space, then reset during a wait.
        cyc(); branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; restart(32'hFFFF_FFFC);
        @(negedge clk); expect_if("hb_fetch", 32'h204, 32'h200, 1'b1);
        cyc(); branch_taken = 1'b0;
        @(negedge clk); chk("wrap_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        cyc(); ifc.imem_ready = 1'b0;
        @(negedge clk); expect_if("wrap", 32'd0, 32'hFFFF_FFFC, 1'b1); chk("wrap_next", ifc.imem_addr, 32'd0);
        cyc(); rst = 1'b1;
        @(negedge clk); chk("rst_wait_addr", ifc.imem_addr, 32'd0);
        cyc(); mem_key = 32'h3C5A_96E1; restart(RESET_PC);

        // Randomized traffic against the program-order scoreboard.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst            = ($urandom_range(0, 199) == 0);
            ifc.imem_ready = ($urandom_range(0, 3) != 0);
            freeze         = ($urandom_range(0, 4) == 0);
            branch_taken   = !rst && ($urandom_range(0, 15) == 0);
            branch_addr    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
            if (rst) restart(RESET_PC);
            else if (branch_taken) restart(branch_addr);
        end

        // Zero-wait memory after reset: one valid instruction every cycle.
        cyc(); rst = 1'b1; branch_taken = 1'b0; freeze = 1'b0; ifc.imem_ready = 1'b1; restart(RESET_PC);
        cyc(); rst = 1'b0;
        cyc();
        for (int k = 0; k < 30; k++) begin
            cyc();
            @(negedge clk); chk("zero_wait_valid", 32'(valid), 32'd1);
        end

        cyc();
        chk("progress", 32'(consumed >= 500), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
